// File: rtl/rgb24_to_rgb8_dither.sv
// ============================================================================
// Module      : rgb24_to_rgb8_dither
// Description : Streaming 24-bit RGB to 8-bit RRRGGGBB colour quantizer with
//               optional 4x4 ordered (Bayer) dithering. Two register stages,
//               valid/ready handshake on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb24_to_rgb8_dither #(
  parameter int H_RES     = 320,
  parameter int V_RES     = 240,
  parameter int DITHER_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sof
);

  // Counters are at least 2 bits wide so the Bayer index bits always exist.
  localparam int c_XW = (H_RES > 4) ? $clog2(H_RES) : 2;
  localparam int c_YW = (V_RES > 4) ? $clog2(V_RES) : 2;

  localparam logic [c_XW-1:0] c_x_last     = c_XW'(H_RES - 1);
  localparam logic [c_YW-1:0] c_y_last     = c_YW'(V_RES - 1);
  // Position following a start-of-frame pixel; a one-pixel line wraps at once.
  localparam logic [c_XW-1:0] c_x_after_sof = (H_RES == 1) ? c_XW'(0) : c_XW'(1);

  // ---------------------------------------------------------------------------
  // Handshake: the whole pipeline moves as one unit whenever the output
  // register is empty or being drained this cycle.
  // ---------------------------------------------------------------------------
  logic w_adv;
  logic w_accept;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_accept = in_valid && w_adv;

  // ---------------------------------------------------------------------------
  // Pixel position tracking
  // ---------------------------------------------------------------------------
  logic [c_XW-1:0] r_x;
  logic [c_YW-1:0] r_y;
  logic [c_XW-1:0] w_px_x;
  logic [c_YW-1:0] w_px_y;

  // A start-of-frame pixel always sits at the origin, whatever the counters say.
  assign w_px_x = in_sof ? c_XW'(0) : r_x;
  assign w_px_y = in_sof ? c_YW'(0) : r_y;

  // Raster-order x/y counters, stepped only on accepted pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (in_sof) begin
        r_x <= c_x_after_sof;
        r_y <= '0;
      end else if (r_x == c_x_last) begin
        r_x <= '0;
        r_y <= (r_y == c_y_last) ? c_YW'(0) : r_y + c_YW'(1);
      end else begin
        r_x <= r_x + c_XW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bayer threshold for the incoming pixel position
  // ---------------------------------------------------------------------------
  logic [3:0] w_bayer;

  generate
    if (DITHER_EN != 0) begin : g_dither
      logic [3:0] w_bayer_lut;

      // 4x4 ordered-dither matrix indexed by {y[1:0], x[1:0]}.
      always_comb begin
        w_bayer_lut = 4'd0;
        case ({w_px_y[1:0], w_px_x[1:0]})
          4'h0: w_bayer_lut = 4'd0;
          4'h1: w_bayer_lut = 4'd8;
          4'h2: w_bayer_lut = 4'd2;
          4'h3: w_bayer_lut = 4'd10;
          4'h4: w_bayer_lut = 4'd12;
          4'h5: w_bayer_lut = 4'd4;
          4'h6: w_bayer_lut = 4'd14;
          4'h7: w_bayer_lut = 4'd6;
          4'h8: w_bayer_lut = 4'd3;
          4'h9: w_bayer_lut = 4'd11;
          4'hA: w_bayer_lut = 4'd1;
          4'hB: w_bayer_lut = 4'd9;
          4'hC: w_bayer_lut = 4'd15;
          4'hD: w_bayer_lut = 4'd7;
          4'hE: w_bayer_lut = 4'd13;
          4'hF: w_bayer_lut = 4'd5;
          default: w_bayer_lut = 4'd0;
        endcase
      end

      assign w_bayer = w_bayer_lut;
    end else begin : g_no_dither
      assign w_bayer = 4'd0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 1: add the threshold scaled to each channel's dropped LSBs.
  // Red/green drop 5 bits (step 32 = 16 levels * 2), blue drops 6 (16 * 4).
  // The 9th bit keeps the carry so stage 2 can saturate instead of wrapping.
  // ---------------------------------------------------------------------------
  logic [8:0] w_rs;
  logic [8:0] w_gs;
  logic [8:0] w_bs;

  assign w_rs = {1'b0, in_data[23:16]} + {4'b0, w_bayer, 1'b0};
  assign w_gs = {1'b0, in_data[15:8]}  + {4'b0, w_bayer, 1'b0};
  assign w_bs = {1'b0, in_data[7:0]}   + {3'b0, w_bayer, 2'b0};

  logic       r_s1_valid;
  logic       r_s1_sof;
  logic [8:0] r_s1_r;
  logic [8:0] r_s1_g;
  logic [8:0] r_s1_b;

  // Stage-1 register: valid follows the accept on every advance, data only
  // loads for real pixels so bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_sof <= in_sof;
        r_s1_r   <= w_rs;
        r_s1_g   <= w_gs;
        r_s1_b   <= w_bs;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: truncate to 3/3/2 bits, saturating any carry-out to full scale.
  // ---------------------------------------------------------------------------
  logic [2:0] w_r3;
  logic [2:0] w_g3;
  logic [1:0] w_b2;

  assign w_r3 = r_s1_r[8] ? 3'd7 : r_s1_r[7:5];
  assign w_g3 = r_s1_g[8] ? 3'd7 : r_s1_g[7:5];
  assign w_b2 = r_s1_b[8] ? 2'd3 : r_s1_b[7:6];

  // Output register: holds its contents whenever the sink stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data <= {w_r3, w_g3, w_b2};
        out_sof  <= r_s1_sof;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rgb24_to_rgb8_dither.sv
// ============================================================================
// Module      : tb_rgb24_to_rgb8_dither
// Description : Directed self-checking bench for rgb24_to_rgb8_dither. Three
//               instances share stimulus: plain truncation (320x240), dithered
//               4x4 raster, and dithered 4x2 raster.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb24_to_rgb8_dither;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_sof;
  logic        out_ready;

  logic       in_ready_a, out_valid_a, out_sof_a;
  logic [7:0] out_data_a;
  logic       in_ready_b, out_valid_b, out_sof_b;
  logic [7:0] out_data_b;
  logic       in_ready_c, out_valid_c, out_sof_c;
  logic [7:0] out_data_c;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic       qs_b[$];
  logic [7:0] q_c[$];
  logic       qs_c[$];

  always #5 clk = ~clk;

  rgb24_to_rgb8_dither #(.H_RES(320), .V_RES(240), .DITHER_EN(0)) u_plain (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_sof(out_sof_a)
  );

  rgb24_to_rgb8_dither #(.H_RES(4), .V_RES(4), .DITHER_EN(1)) u_dith44 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_sof(out_sof_b)
  );

  rgb24_to_rgb8_dither #(.H_RES(4), .V_RES(2), .DITHER_EN(1)) u_dith42 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_data(out_data_c), .out_sof(out_sof_c)
  );

  // Record every output transfer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && out_ready) begin
      if (out_valid_a) q_a.push_back(out_data_a);
      if (out_valid_b) begin
        q_b.push_back(out_data_b);
        qs_b.push_back(out_sof_b);
      end
      if (out_valid_c) begin
        q_c.push_back(out_data_c);
        qs_c.push_back(out_sof_c);
      end
    end
  end

  // 8-bit code expanded back to 24 bits by bit replication.
  function automatic logic [23:0] expand(input logic [7:0] c);
    logic [2:0] r, g;
    logic [1:0] b;
    r = c[7:5];
    g = c[4:2];
    b = c[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  task automatic clear_q();
    q_a.delete();
    q_b.delete();
    qs_b.delete();
    q_c.delete();
    qs_c.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one pixel and hold it until accepted (bounded wait).
  task automatic drive_px(input logic [23:0] d, input logic s);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    @(negedge clk);
    while (!in_ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) begin
      n_checks++;
      n_fails++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready_a);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    idle(3);
    n_checks++;
    if ({out_valid_a, out_valid_b, out_valid_c} !== 3'b000) begin
      n_fails++;
      $display("FAIL reset_out_valid: got %b%b%b required 000", out_valid_a, out_valid_b, out_valid_c);
    end
    n_checks++;
    if (out_data_a !== 8'h00 || out_data_b !== 8'h00) begin
      n_fails++;
      $display("FAIL reset_out_data: got %h/%h required 00/00", out_data_a, out_data_b);
    end
    n_checks++;
    if (out_sof_a !== 1'b0 || out_sof_b !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_out_sof: got %b/%b required 0/0", out_sof_a, out_sof_b);
    end
    reset = 1'b0;
    idle(1);
    n_checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
      n_fails++;
      $display("FAIL post_reset_idle: in_ready=%b out_valid=%b required 1/0", in_ready_a, out_valid_a);
    end
  endtask

  task automatic test_truncation();
    logic [23:0] tv[3];
    logic [7:0]  te[3];
    tv = '{24'hFFFFFF, 24'h204060, 24'h000000};
    te = '{8'hFF, 8'h29, 8'h00};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = tv[i];
      in_sof   = 1'b0;
      idle(1);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid_a !== 1'b0) begin
        n_fails++;
        $display("FAIL trunc_latency_early[%0d]: out_valid=%b required 0", i, out_valid_a);
      end
      idle(1);
      n_checks++;
      if (out_valid_a !== 1'b1 || out_data_a !== te[i]) begin
        n_fails++;
        $display("FAIL trunc_value[%0d]: valid=%b data=%h required 1/%h", i, out_valid_a, out_data_a, te[i]);
      end
      idle(1);
    end
  endtask

  task automatic test_all_codes();
    clear_q();
    for (int c = 0; c < 256; c++) drive_px(expand(8'(c)), 1'b0);
    idle(4);
    n_checks++;
    if (q_a.size() != 256) begin
      n_fails++;
      $display("FAIL codes_count: got %0d required 256", q_a.size());
    end
    for (int i = 0; i < 256 && i < q_a.size(); i++) begin
      n_checks++;
      if (q_a[i] !== 8'(i)) begin
        n_fails++;
        $display("FAIL codes_value[%0d]: got %h required %h", i, q_a[i], 8'(i));
      end
    end
  endtask

  task automatic test_dither_pattern();
    logic [7:0] exp_tab[16];
    int n_r, n_b;
    exp_tab = '{8'h00, 8'h24, 8'h00, 8'h24,
                8'h25, 8'h00, 8'h25, 8'h00,
                8'h00, 8'h24, 8'h00, 8'h24,
                8'h25, 8'h00, 8'h25, 8'h00};
    clear_q();
    for (int k = 0; k < 16; k++) drive_px(24'h101010, k == 0);
    idle(4);
    n_checks++;
    if (q_b.size() != 16) begin
      n_fails++;
      $display("FAIL dither_count: got %0d required 16", q_b.size());
    end
    n_r = 0;
    n_b = 0;
    for (int k = 0; k < 16 && k < q_b.size(); k++) begin
      n_checks++;
      if (q_b[k] !== exp_tab[k] || qs_b[k] !== (k == 0)) begin
        n_fails++;
        $display("FAIL dither_px[x=%0d,y=%0d]: data=%h sof=%b required %h/%b",
                 k % 4, k / 4, q_b[k], qs_b[k], exp_tab[k], (k == 0));
      end
      if (q_b[k][7:5] == 3'd1) n_r++;
      if (q_b[k][1:0] == 2'd1) n_b++;
    end
    n_checks++;
    if (n_r != 8 || n_b != 4) begin
      n_fails++;
      $display("FAIL dither_hist: r1=%0d b1=%0d required 8/4", n_r, n_b);
    end
  endtask

  task automatic test_dither_saturate();
    clear_q();
    for (int k = 0; k < 16; k++) drive_px(24'hFFFFFF, k == 0);
    idle(4);
    n_checks++;
    if (q_b.size() != 16) begin
      n_fails++;
      $display("FAIL sat_count: got %0d required 16", q_b.size());
    end
    for (int k = 0; k < 16 && k < q_b.size(); k++) begin
      n_checks++;
      if (q_b[k] !== 8'hFF) begin
        n_fails++;
        $display("FAIL sat_px[%0d]: got %h required ff", k, q_b[k]);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [7:0] held;
    clear_q();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) drive_px(expand(8'(i * 37 + 5)), 1'b0);
      end
      begin
        idle(8);
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data_a;
        for (int k = 0; k < 5; k++) begin
          n_checks++;
          if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_data_a !== held) begin
            n_fails++;
            $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b data=%h required 0/1/%h",
                     k, in_ready_a, out_valid_a, out_data_a, held);
          end
          if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);
    n_checks++;
    if (q_a.size() != 24) begin
      n_fails++;
      $display("FAIL stall_count: got %0d required 24", q_a.size());
    end
    for (int i = 0; i < 24 && i < q_a.size(); i++) begin
      n_checks++;
      if (q_a[i] !== 8'(i * 37 + 5)) begin
        n_fails++;
        $display("FAIL stall_value[%0d]: got %h required %h", i, q_a[i], 8'(i * 37 + 5));
      end
    end
  endtask

  task automatic test_sof_restart_and_reset();
    logic [7:0] e;
    clear_q();
    // Red 0x1F becomes 1 for any nonzero threshold, 0 only at b=0.
    for (int k = 0; k < 11; k++) drive_px(24'h1F0000, (k == 0) || (k == 2));
    idle(4);
    n_checks++;
    if (q_c.size() != 11) begin
      n_fails++;
      $display("FAIL sof_count: got %0d required 11", q_c.size());
    end
    for (int k = 0; k < 11 && k < q_c.size(); k++) begin
      e = ((k == 0) || (k == 2) || (k == 10)) ? 8'h00 : 8'h20;
      n_checks++;
      if (q_c[k] !== e || qs_c[k] !== ((k == 0) || (k == 2))) begin
        n_fails++;
        $display("FAIL sof_px[%0d]: data=%h sof=%b required %h/%b",
                 k, q_c[k], qs_c[k], e, ((k == 0) || (k == 2)));
      end
    end

    clear_q();
    drive_px(24'h1F0000, 1'b1);
    drive_px(24'h1F0000, 1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    n_checks++;
    if (out_valid_c !== 1'b0) begin
      n_fails++;
      $display("FAIL midreset_valid: got %b required 0", out_valid_c);
    end
    drive_px(24'h1F0000, 1'b0);
    idle(4);
    n_checks++;
    if (q_c.size() != 1) begin
      n_fails++;
      $display("FAIL midreset_count: got %0d required 1", q_c.size());
    end else begin
      n_checks++;
      if (q_c[0] !== 8'h00) begin
        n_fails++;
        $display("FAIL midreset_origin: got %h required 00", q_c[0]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_truncation();
    test_all_codes();
    test_dither_pattern();
    test_dither_saturate();
    test_back_to_back_stall();
    test_sof_restart_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
